capture_sched: RTL
==================

Name: capture_sched

Overview:
- Packet-granular 2-input AXI-Stream scheduler between the packet duplicator outputs and the downstream datapath.
- Port 0 carries forwarded traffic; port 1 carries the capture copy.
- Weighted round-robin: port 0 gets up to WEIGHT packets per port-1 packet. Capture packets are drained and counted when capture is disabled.
- Supplies the status counters read through the register block.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, data width of all streams
- C_M_AXIS_TUSER_WIDTH, 128, tuser width of all streams
- C_WEIGHT_WIDTH, 8, width of the weight input and the credit counter
- C_CNT_WIDTH, 32, width of the status counters

Ports:
- axi_aclk  in  1  sole clock
- axi_reset  in  1  synchronous active-high reset
- s_axis_tdata_0/_1  in  C_M_AXIS_DATA_WIDTH  input data, port 0 (forward) / port 1 (capture)
- s_axis_tstrb_0/_1  in  C_M_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser_0/_1  in  C_M_AXIS_TUSER_WIDTH  sideband
- s_axis_tvalid_0/_1  in  1  valid
- s_axis_tready_0/_1  out  1  ready
- s_axis_tlast_0/_1  in  1  last beat
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  output data
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  output strobes
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  output sideband
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- cap_enable  in  1  capture enable, from wo_regs bit 0
- weight  in  C_WEIGHT_WIDTH  port-0 packets per port-1 grant; 0 is treated as 1
- drop_cnt  out  C_CNT_WIDTH  capture packets discarded

Behaviour:
- Clock and reset: single clock axi_aclk; reset is synchronous active-high axi_reset.
- Reset values: state=IDLE, credit=0, drop_cnt=0, all tready=0, m_axis_tvalid=0, m_axis_tlast=0. m_axis_tdata/tstrb/tuser are muxed from port 0.
- States: IDLE, PKT0, PKT1, DRAIN1.
- IDLE: all tready=0, m_axis_tvalid=0. Arbitration is evaluated each cycle; eff_w = (weight==0) ? 1 : weight.
  - valid0 and (!valid1 or credit<eff_w) -> PKT0; credit = min(credit+1, eff_w).
  - else valid1 and cap_enable -> PKT1; credit=0.
  - else valid1 and !cap_enable -> DRAIN1; credit unchanged.
  - neither valid -> stay in IDLE.
- PKT0/PKT1: combinational pass-through of the granted port.
  - m_axis_* = s_axis_*_x; s_axis_tready_x = m_axis_tready; other port tready=0.
  - Exit to IDLE on the cycle of tvalid & tready & tlast.
- DRAIN1: s_axis_tready_1=1, m_axis_tvalid=0, s_axis_tready_0=0.
  - On tvalid_1 & tlast_1: drop_cnt += 1 (saturating at all-ones); go to IDLE.
- Latency: first beat appears on m_axis one cycle after tvalid is seen in IDLE. One idle bubble follows every packet end.
- Sampling: cap_enable and weight are sampled only in IDLE. Changes mid-packet do not affect the packet in progress.
- Grants are never switched mid-packet. A held-off tvalid with m_axis_tready=0 keeps the state unchanged indefinitely.
- Weight reduced below the current credit: the next contended arbitration grants port 1.
- Reset asserted mid-packet: return to IDLE next cycle with reset values. The remaining beats of the interrupted packet re-enter arbitration as a new packet.

Optional Feature:
- Macro CAPTURE_SCHED_PKT_CNT_EN.
- Defined: adds outputs pkt_cnt_0 and pkt_cnt_1 (C_CNT_WIDTH each). Each increments, saturating, on the tlast handshake of a packet forwarded in PKT0 or PKT1 respectively. Reset value 0.
- Undefined: ports and counters are absent; drop_cnt is unaffected.

Test Plan:
- Both ports continuously offer 1-beat packets, weight=3, cap_enable=1 -> grant order 0,0,0,1,0,0,0,1; every packet followed by exactly one idle cycle.
- weight=0, both ports busy -> strict alternation 0,1,0,1.
- cap_enable=0, port 1 sends 4-beat packets, port 0 idle -> m_axis_tvalid stays 0, s_axis_tready_1=1 for 4 cycles per packet, drop_cnt 0->1->2.
- Port 0 sends a 5-beat packet while m_axis_tready toggles 1,0,1,0; port 1 valid throughout -> all 5 beats in order, no port-1 beat interleaved, s_axis_tready_1=0 until after tlast.
- axi_reset pulsed at beat 2 of a 4-beat port-1 packet -> next cycle all outputs at reset values and drop_cnt=0; beats 3-4 are arbitrated as a new packet.
- With CAPTURE_SCHED_PKT_CNT_EN: 10 forward and 3 capture packets -> pkt_cnt_0=10, pkt_cnt_1=3. Counters saturate at 0xFFFFFFFF when preloaded to all-ones minus 1 and fed 2 packets.

Source files
------------

// File: rtl/capture_sched_if.sv
// AXI-Stream link bundle shared by the capture_sched inputs and output.
interface capture_sched_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/capture_sched.sv
// Packet-granular weighted round-robin between forward (port 0) and capture (port 1) streams.
// Optional per-port forwarded-packet counters: define CAPTURE_SCHED_PKT_CNT_EN.
//
// state  | meaning
// IDLE   | no grant; arbitrate among valid inputs
// PKT0   | forwarding a port-0 packet
// PKT1   | forwarding a port-1 (capture) packet
// DRAIN1 | discarding a port-1 packet while capture is disabled
module capture_sched #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_WEIGHT_WIDTH       = 8,
    parameter int C_CNT_WIDTH          = 32
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,
    capture_sched_if.slave            s_axis_0,
    capture_sched_if.slave            s_axis_1,
    capture_sched_if.master           m_axis,
    input  logic                      cap_enable,
    input  logic [C_WEIGHT_WIDTH-1:0] weight,
    output logic [C_CNT_WIDTH-1:0]    drop_cnt
`ifdef CAPTURE_SCHED_PKT_CNT_EN
    ,
    output logic [C_CNT_WIDTH-1:0]    pkt_cnt_0,
    output logic [C_CNT_WIDTH-1:0]    pkt_cnt_1
`endif
);

    typedef enum logic [1:0] {IDLE, PKT0, PKT1, DRAIN1} state_t;

    state_t                        state;
    logic [C_WEIGHT_WIDTH-1:0]     credit;
    logic [C_WEIGHT_WIDTH-1:0]     eff_w;
    logic                          v0, v1, last0, last1;
    logic                          done0, done1;

    logic [C_M_AXIS_DATA_WIDTH-1:0]   data_mux;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] strb_mux;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  user_mux;
    logic                             valid_mux, last_mux, rdy0, rdy1;

    assign v0    = s_axis_0.tvalid;
    assign v1    = s_axis_1.tvalid;
    assign last0 = s_axis_0.tlast;
    assign last1 = s_axis_1.tlast;
    assign eff_w = (weight == '0) ? C_WEIGHT_WIDTH'(1) : weight;
    assign done0 = v0 & m_axis.tready & last0;
    assign done1 = v1 & m_axis.tready & last1;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state    <= IDLE;
            credit   <= '0;
            drop_cnt <= '0;
`ifdef CAPTURE_SCHED_PKT_CNT_EN
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // credit saturates at eff_w; a credit left above a lowered weight still yields to port 1
                    if (v0 && (!v1 || credit < eff_w)) begin
                        state  <= PKT0;
                        credit <= (credit < eff_w) ? credit + C_WEIGHT_WIDTH'(1) : eff_w;
                    end else if (v1 && cap_enable) begin
                        state  <= PKT1;
                        credit <= '0;
                    end else if (v1) begin
                        state <= DRAIN1;
                    end
                end
                PKT0: begin
                    if (done0) begin
                        state <= IDLE;
`ifdef CAPTURE_SCHED_PKT_CNT_EN
                        if (pkt_cnt_0 != '1) pkt_cnt_0 <= pkt_cnt_0 + C_CNT_WIDTH'(1);
`endif
                    end
                end
                PKT1: begin
                    if (done1) begin
                        state <= IDLE;
`ifdef CAPTURE_SCHED_PKT_CNT_EN
                        if (pkt_cnt_1 != '1) pkt_cnt_1 <= pkt_cnt_1 + C_CNT_WIDTH'(1);
`endif
                    end
                end
                DRAIN1: begin
                    if (v1 && last1) begin
                        state <= IDLE;
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + C_CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pass-through is combinational so a granted packet streams at full rate.
    always_comb begin
        data_mux  = s_axis_0.tdata;
        strb_mux  = s_axis_0.tstrb;
        user_mux  = s_axis_0.tuser;
        valid_mux = 1'b0;
        last_mux  = 1'b0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        case (state)
            PKT0: begin
                valid_mux = v0;
                last_mux  = last0;
                rdy0      = m_axis.tready;
            end
            PKT1: begin
                data_mux  = s_axis_1.tdata;
                strb_mux  = s_axis_1.tstrb;
                user_mux  = s_axis_1.tuser;
                valid_mux = v1;
                last_mux  = last1;
                rdy1      = m_axis.tready;
            end
            DRAIN1: rdy1 = 1'b1;
            default: ;
        endcase
    end

    assign m_axis.tdata    = data_mux;
    assign m_axis.tstrb    = strb_mux;
    assign m_axis.tuser    = user_mux;
    assign m_axis.tvalid   = valid_mux;
    assign m_axis.tlast    = last_mux;
    assign s_axis_0.tready = rdy0;
    assign s_axis_1.tready = rdy1;

endmodule
